// File: rtl/sort_bitplane_buffer_pkg.sv
// Shared constants and state encoding for the sort bitplane buffer.
//   ELEMENT_NUM      : elements per batch (power of 2)
//   DATA_WIDTH       : bits per element
//   LOG2_ELEMENT_NUM : element index width
//   LOG2_DATA_WIDTH  : bit-column address width
//   state_t          : LOAD -> SORT -> DONE -> LOAD
package sort_bitplane_buffer_pkg;

  localparam int unsigned ELEMENT_NUM      = 16;
  localparam int unsigned DATA_WIDTH       = 8;
  localparam int unsigned LOG2_ELEMENT_NUM = 4;
  localparam int unsigned LOG2_DATA_WIDTH  = 3;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sort_bitplane_buffer_if.sv
// Bus between the element buffer and its environment (loader + sorting engine).
//   Load side   : in_valid, in_data  -> buffer ; in_ready -> loader
//   Engine side : bit_addr, SM_valid, LE_Addr -> buffer ; flag, bit_data, eng_clr -> engine
//   Result side : out_valid, out_data, out_addr, done -> consumer
//   master : environment view (drives inputs, observes results)
//   slave  : buffer view
interface sort_bitplane_buffer_if;
  import sort_bitplane_buffer_pkg::*;

  logic                        in_valid;
  logic [DATA_WIDTH-1:0]       in_data;
  logic                        in_ready;
  logic                        flag;
  logic [LOG2_DATA_WIDTH-1:0]  bit_addr;
  logic [ELEMENT_NUM-1:0]      bit_data;
  logic                        SM_valid;
  logic [LOG2_ELEMENT_NUM-1:0] LE_Addr;
  logic                        out_valid;
  logic [DATA_WIDTH-1:0]       out_data;
  logic [LOG2_ELEMENT_NUM-1:0] out_addr;
  logic                        done;
  logic                        eng_clr;

  modport master (
    output in_valid, in_data, bit_addr, SM_valid, LE_Addr,
    input  in_ready, flag, bit_data, out_valid, out_data, out_addr, done, eng_clr
  );

  modport slave (
    input  in_valid, in_data, bit_addr, SM_valid, LE_Addr,
    output in_ready, flag, bit_data, out_valid, out_data, out_addr, done, eng_clr
  );

endinterface

// File: rtl/sort_bitplane_buffer_bitplane_mux.sv
// Combinational bit-column selector.
//   i_mem_flat : all elements, element j at [j*DATA_WIDTH +: DATA_WIDTH]
//   i_bit_addr : selected bit column
//   o_bit_data : o_bit_data[j] = element j, bit i_bit_addr; zero when out of range
module bitplane_mux
  import sort_bitplane_buffer_pkg::*;
(
  input  logic [ELEMENT_NUM*DATA_WIDTH-1:0] i_mem_flat,
  input  logic [LOG2_DATA_WIDTH-1:0]        i_bit_addr,
  output logic [ELEMENT_NUM-1:0]            o_bit_data
);

  // Matching only in-range columns leaves out-of-range addresses at zero.
  always_comb begin
    o_bit_data = '0;
    for (int unsigned b = 0; b < DATA_WIDTH; b++) begin
      if (i_bit_addr == LOG2_DATA_WIDTH'(b)) begin
        for (int unsigned j = 0; j < ELEMENT_NUM; j++) begin
          o_bit_data[j] = i_mem_flat[j*DATA_WIDTH + b];
        end
      end
    end
  end

endmodule

// File: rtl/sort_bitplane_buffer.sv
// Element store wrapped around the bit-serial sorting engine.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : slave side of sort_bitplane_buffer_if
// LOAD accepts ELEMENT_NUM words, SORT serves bit columns and returns the stored
// word for each engine index, DONE pulses done/eng_clr for one cycle.
module sort_bitplane_buffer
  import sort_bitplane_buffer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  sort_bitplane_buffer_if.slave bus
);

  state_t                        r_state;
  state_t                        w_next_state;
  logic [DATA_WIDTH-1:0]         r_mem [ELEMENT_NUM];
  logic [LOG2_ELEMENT_NUM-1:0]   r_wr_cnt;
  logic [LOG2_ELEMENT_NUM:0]     r_rd_cnt;
  logic                          r_flag;
  logic                          r_in_ready;
  logic                          r_out_valid;
  logic [DATA_WIDTH-1:0]         r_out_data;
  logic [LOG2_ELEMENT_NUM-1:0]   r_out_addr;
  logic                          r_done;
  logic                          r_eng_clr;

  logic                          w_accept;
  logic                          w_emit;
  logic                          w_last_wr;
  logic                          w_last_rd;
  logic                          w_flag_d;
  logic                          w_in_ready_d;
  logic                          w_done_d;
  logic [ELEMENT_NUM*DATA_WIDTH-1:0] w_mem_flat;
  logic [ELEMENT_NUM-1:0]        w_bit_data;

  assign w_accept  = (r_state == LOAD) && bus.in_valid && r_in_ready;
  assign w_emit    = (r_state == SORT) && bus.SM_valid;
  assign w_last_wr = (r_wr_cnt == LOG2_ELEMENT_NUM'(ELEMENT_NUM - 1));
  assign w_last_rd = (r_rd_cnt == (LOG2_ELEMENT_NUM + 1)'(ELEMENT_NUM - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Registered status outputs are loaded from the next state so they always
  // describe the state the FSM is currently in.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      LOAD:    if (w_accept && w_last_wr) w_next_state = SORT;
      SORT:    if (w_emit && w_last_rd)   w_next_state = DONE;
      DONE:    w_next_state = LOAD;
      default: w_next_state = LOAD;
    endcase
    w_flag_d     = (w_next_state != SORT);
    w_in_ready_d = (w_next_state == LOAD);
    w_done_d     = (w_next_state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ELEMENT_NUM; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_flag      <= 1'b1;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_done      <= 1'b0;
      r_eng_clr   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mem[r_wr_cnt] <= bus.in_data;
        r_wr_cnt        <= w_last_wr ? '0 : r_wr_cnt + 1'b1;
      end

      r_out_valid <= w_emit;
      if (w_emit) begin
        r_out_data <= r_mem[bus.LE_Addr];
        r_out_addr <= bus.LE_Addr;
        r_rd_cnt   <= r_rd_cnt + 1'b1;
      end
      if (r_state == DONE) begin
        r_rd_cnt <= '0;
      end

      r_flag     <= w_flag_d;
      r_in_ready <= w_in_ready_d;
      r_done     <= w_done_d;
      r_eng_clr  <= w_done_d;
    end
  end

  always_comb begin
    w_mem_flat = '0;
    for (int unsigned i = 0; i < ELEMENT_NUM; i++) begin
      w_mem_flat[i*DATA_WIDTH +: DATA_WIDTH] = r_mem[i];
    end
  end

  bitplane_mux u_bitplane_mux (
    .i_mem_flat (w_mem_flat),
    .i_bit_addr (bus.bit_addr),
    .o_bit_data (w_bit_data)
  );

  assign bus.bit_data  = w_bit_data;
  assign bus.flag      = r_flag;
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_addr  = r_out_addr;
  assign bus.done      = r_done;
  assign bus.eng_clr   = r_eng_clr;

endmodule
